// File: rtl/d_ff.sv
// Width-parameterised D flip-flop with asynchronous active-high reset and
// a combinational complement output.
module d_ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] qb
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q <= RESET_VAL;
        end else begin
            Q <= d;
        end
    end

    // Derived from Q directly so the two outputs can never be out of step.
    assign qb = ~Q;

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: a 1-bit and an 8-bit instance are driven from directed
// vectors and checked against literal values and an edge-history model.
module tb_d_ff;

    logic       clk = 1'b0;
    logic       reset1, reset8;
    logic [0:0] d1, q1, qb1;
    logic [7:0] d8, q8, qb8;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    d_ff u_dff1 (
        .clk   (clk),
        .reset (reset1),
        .d     (d1),
        .Q     (q1),
        .qb    (qb1)
    );

    d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dff8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
        .Q     (q8),
        .qb    (qb8)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Model: remember what d was at the most recent rising edge and whether
    // reset has been seen high since then; reset asserted at any point wins.
    logic [0:0] edge_d1;
    logic [7:0] edge_d8;
    bit         rst_seen1 = 1'b0, rst_seen8 = 1'b0;
    bit         valid1 = 1'b0, valid8 = 1'b0;

    always @(posedge clk) begin
        edge_d1   = d1;
        edge_d8   = d8;
        rst_seen1 = (reset1 === 1'b1);
        rst_seen8 = (reset8 === 1'b1);
        valid1    = 1'b1;
        valid8    = 1'b1;
    end

    always @(posedge reset1) begin rst_seen1 = 1'b1; valid1 = 1'b1; end
    always @(posedge reset8) begin rst_seen8 = 1'b1; valid8 = 1'b1; end

    function automatic logic [0:0] model_q1();
        return (reset1 === 1'b1 || rst_seen1) ? 1'b0 : edge_d1;
    endfunction

    function automatic logic [7:0] model_q8();
        return (reset8 === 1'b1 || rst_seen8) ? 8'hA5 : edge_d8;
    endfunction

    // Per-cycle comparison, away from both clock edges and stimulus times.
    always @(posedge clk) begin
        #2;
        if (valid1) begin
            check("model_q1",  {7'b0, q1},  {7'b0, model_q1()});
            check("model_qb1", {7'b0, qb1}, {7'b0, ~model_q1()});
        end
        if (valid8) begin
            check("model_q8",  q8,  model_q8());
            check("model_qb8", qb8, ~model_q8());
        end
    end

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    initial begin
        reset1 = 1'b0; d1 = 1'b0;
        reset8 = 1'b1; d8 = 8'h00;

        at(1);
        check("w8_reset_q",  q8,  8'hA5);
        check("w8_reset_qb", qb8, 8'h5A);
        at(6);
        check("w1_first_edge_q",  {7'b0, q1},  8'h00);
        check("w1_first_edge_qb", {7'b0, qb1}, 8'h01);
        check("w8_reset_over_edge", q8, 8'hA5);

        at(10);
        d1 = 1'b1; reset1 = 1'b1;
        reset8 = 1'b0; d8 = 8'h3C;
        at(11);
        check("w1_reset_immediate_q",  {7'b0, q1},  8'h00);
        check("w1_reset_immediate_qb", {7'b0, qb1}, 8'h01);
        at(16);
        check("w1_reset_beats_d", {7'b0, q1}, 8'h00);
        check("w8_capture_q",  q8,  8'h3C);
        check("w8_capture_qb", qb8, 8'hC3);

        at(20);
        reset1 = 1'b0; d1 = 1'b0; d8 = 8'hFF;
        at(26);
        check("w1_d0_edge25", {7'b0, q1}, 8'h00);
        check("w8_capture_ff", q8, 8'hFF);
        check("w8_capture_ff_qb", qb8, 8'h00);

        at(30);
        d8 = 8'h81;
        at(32);
        reset8 = 1'b1;
        at(33);
        check("w8_midcycle_reset", q8, 8'hA5);
        at(36);
        check("w1_d0_edge35", {7'b0, q1}, 8'h00);
        check("w8_reset_held", q8, 8'hA5);

        at(40);
        d1 = 1'b1; reset8 = 1'b0;
        at(46);
        check("w1_capture1_q",  {7'b0, q1},  8'h01);
        check("w1_capture1_qb", {7'b0, qb1}, 8'h00);
        check("w8_after_release", q8, 8'h81);

        at(50);
        d1 = 1'b0;
        at(51);
        check("w1_hold_after_fall", {7'b0, q1}, 8'h01);
        at(54);
        check("w1_hold_mid_low", {7'b0, q1}, 8'h01);
        at(56);
        check("w1_capture0", {7'b0, q1}, 8'h00);

        at(60);
        d1 = 1'b1;
        at(66);
        check("w1_q_high_again", {7'b0, q1}, 8'h01);

        at(72);
        reset1 = 1'b1; d1 = 1'b0;
        at(73);
        check("w1_midcycle_reset_q",  {7'b0, q1},  8'h00);
        check("w1_midcycle_reset_qb", {7'b0, qb1}, 8'h01);
        at(76);
        check("w1_reset_edge75", {7'b0, q1}, 8'h00);
        at(86);
        check("w1_reset_edge85", {7'b0, q1}, 8'h00);

        at(90);
        reset1 = 1'b0; d1 = 1'b1;
        at(96);
        check("w1_first_edge_after_reset_q",  {7'b0, q1},  8'h01);
        check("w1_first_edge_after_reset_qb", {7'b0, qb1}, 8'h00);

        at(110);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/d_ff.md
D_FF -- requirements
Module: d_ff

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clock port clk, reset port reset.
REQ-002 Parameter WIDTH, default 1: bit width of d, Q and qb.
REQ-003 Parameter RESET_VAL, default all-zeros (WIDTH bits): value loaded into Q while reset is high.
REQ-004 Port clk, input, 1: clock; all captures occur on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port d, input, WIDTH: data to capture.
REQ-007 Port Q, output, WIDTH: registered data.
REQ-008 Port qb, output, WIDTH: bitwise complement of Q; may be left unconnected by the parent.

Function
REQ-009 On each rising edge of clk with reset low, Q SHALL take the value of d sampled at that edge; latency is one edge.
REQ-010 Between rising edges, Q SHALL hold its value regardless of changes on d.
REQ-011 qb SHALL always equal ~Q combinationally, with no extra register stage, and SHALL never disagree with Q.
REQ-012 Falling edges of clk SHALL have no effect.
REQ-013 If d changes at the same time as a rising edge, Q SHALL take the pre-edge value of d (standard flop setup semantics).
REQ-014 Before the first reset or first rising edge, Q is unspecified; the parent SHALL NOT rely on it.
REQ-015 Q and qb SHALL be driven only by flop state and combinational inversion, with no latches or gated clocks.

Reset
REQ-016 While reset is high, Q SHALL equal RESET_VAL and qb SHALL equal ~RESET_VAL, independent of clk and d.
REQ-017 Assertion of reset SHALL take effect immediately, without waiting for a clk edge, including mid-cycle.
REQ-018 Reset SHALL have priority over data capture: if a rising edge of clk occurs while reset is high, Q SHALL stay at RESET_VAL.
REQ-019 After reset falls, the first rising edge of clk SHALL capture d normally.
REQ-020 Reset is not synchronised internally; synchronising reset deassertion is the parent's responsibility.

Structure
REQ-021 The block SHALL have no shared package, because it has no typedefs or shared constants; WIDTH and RESET_VAL are local parameters of the module.
REQ-022 The block SHALL be a single module with no sub-modules: one always block sensitive to posedge clk and posedge reset, plus one continuous assignment for qb.
REQ-023 The implementation SHALL use the same RTL for WIDTH=1 and WIDTH>1, with no special-casing.

Verification
REQ-024 The bench SHALL use a 10-time-unit clk period (toggle every 5) and cover the following scenarios.
REQ-025 reset=0, d=0 at t=0 -> Q=0, qb=1 after the rising edge at t=5.
REQ-026 d=1, reset=1 at t=10 -> Q=0, qb=1 immediately, and still 0 after the rising edge at t=15 (reset beats d).
REQ-027 reset=0, d=0 for two cycles (t=20..40) -> Q=0 at the edges at t=25 and t=35.
REQ-028 reset=0, d=1 -> Q=1, qb=0 after the next rising edge; then d toggled on the falling edge -> Q unchanged until the following rising edge.
REQ-029 With Q=1, reset asserted mid-cycle (clk low) -> Q=0 before any clk edge; d=0 with reset=1 across further edges -> Q stays 0.
REQ-030 WIDTH=8, RESET_VAL=8'hA5: reset -> Q=8'hA5, qb=8'h5A; reset released, d=8'h3C -> Q=8'h3C, qb=8'hC3 after one rising edge.
